// File: rtl/acc_requant.sv
// rtl/acc_requant.sv - MAC output stage: bias add, round/shift, saturate to OUT_W, result FIFO
// Optional: define REQUANT_RELU_EN to clamp negative results to zero before saturation.
module acc_requant #(
   parameter int ACC_W      = 40,
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ACC_W-1:0] acc_in,
   input  logic             acc_valid,
   input  logic [31:0]      bias,
   input  logic [5:0]       shift_amt,
   output logic             acc_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             clr_ovf,
   output logic             ovf_flag,
   output logic [15:0]      sat_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = ACC_W + 2;
   localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

   // stage 1: bias add and shift clamp
   logic signed [ACC_W:0] sum_c;
   logic [5:0]            sh_c;
   logic                  s1_valid;
   logic signed [ACC_W:0] s1_sum;
   logic [5:0]            s1_sh;

   assign sum_c = $signed({acc_in[ACC_W-1], acc_in})
                + $signed({{(ACC_W+1-32){bias[31]}}, bias});
   assign sh_c  = (shift_amt > 6'(ACC_W)) ? 6'(ACC_W) : shift_amt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         s1_sh    <= '0;
      end else begin
         s1_valid <= acc_valid;
         if (acc_valid) begin
            s1_sum <= sum_c;
            s1_sh  <= sh_c;
         end
      end
   end

   // stage 2: round half toward +inf, arithmetic shift, saturate
   logic signed [SW-1:0]  ext;
   logic signed [SW-1:0]  rnd;
   logic signed [SW-1:0]  t;
   logic [OUT_W-1:0]      q_c;
   logic                  sat_c;
   logic                  s2_valid;
   logic [OUT_W-1:0]      s2_data;
   logic                  s2_sat;

   always_comb begin
      ext = {s1_sum[ACC_W], s1_sum};
      rnd = '0;
      if (s1_sh != 6'd0)
         rnd[s1_sh - 6'd1] = 1'b1;
      t = (ext + rnd) >>> s1_sh;
`ifdef REQUANT_RELU_EN
      if (t[SW-1])
         t = '0;
`endif
      sat_c = 1'b0;
      q_c   = t[OUT_W-1:0];
      if (t > MAX_V) begin
         q_c   = MAX_V[OUT_W-1:0];
         sat_c = 1'b1;
      end else if (t < MIN_V) begin
         q_c   = MIN_V[OUT_W-1:0];
         sat_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_sat   <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= q_c;
            s2_sat  <= sat_c;
         end
      end
   end

   // result FIFO, first-word fall-through
   logic [OUT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             pop;
   logic             push;
   logic [AW+1:0]    pending;

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign push      = s2_valid && (!full || pop);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign pending   = (AW+2)'(count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
   assign acc_ready = (pending < (AW+2)'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= s2_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // a new drop outranks a same-edge clear; sat_cnt clear suppresses that edge's increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_flag <= 1'b0;
         sat_cnt  <= '0;
      end else begin
         if (s2_valid && !push)
            ovf_flag <= 1'b1;
         else if (clr_ovf)
            ovf_flag <= 1'b0;
         if (clr_ovf)
            sat_cnt <= '0;
         else if (s2_valid && s2_sat && (sat_cnt != 16'hFFFF))
            sat_cnt <= sat_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_acc_requant.sv
// tb/tb_acc_requant.sv - self-checking bench for acc_requant with arithmetic reference model
module tb_acc_requant;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [39:0] acc_in = '0;
   logic        acc_valid = 1'b0;
   logic [31:0] bias = '0;
   logic [5:0]  shift_amt = '0;
   logic        acc_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        clr_ovf = 1'b0;
   logic        ovf_flag;
   logic [15:0] sat_cnt;

   int total = 0;
   int bad = 0;

   acc_requant dut (
      .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .acc_valid(acc_valid),
      .bias(bias), .shift_amt(shift_amt), .acc_ready(acc_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .clr_ovf(clr_ovf), .ovf_flag(ovf_flag), .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic longint floor_div(input longint n, input longint d);
      longint q;
      q = n / d;
      if ((n % d) != 0 && n < 0)
         q = q - 1;
      return q;
   endfunction

   function automatic logic [15:0] model(input longint a, input longint b, input int sh, output bit sat);
      longint s, t, p;
      int e;
      s = a + b;
      e = (sh > 40) ? 40 : sh;
      if (e == 0) begin
         t = s;
      end else begin
         p = longint'(1) << e;
         t = floor_div(s + p / 2, p);
      end
      sat = 1'b0;
`ifdef REQUANT_RELU_EN
      if (t < 0)
         t = 0;
`endif
      if (t > 32767) begin
         t = 32767;
         sat = 1'b1;
      end else if (t < -32768) begin
         t = -32768;
         sat = 1'b1;
      end
      return 16'(t);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [39:0] a, input logic [31:0] b, input logic [5:0] s);
      acc_valid = 1'b1;
      acc_in = a;
      bias = b;
      shift_amt = s;
      tick();
      acc_valid = 1'b0;
   endtask

   task automatic one_result(input logic [39:0] a, input logic [31:0] b, input logic [5:0] s,
                             output logic v, output logic [15:0] d);
      pulse(a, b, s);
      tick();
      tick();
      v = out_valid;
      d = out_data;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic clear_flags;
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      total += 5;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      if (out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data: got %h exp 0000", out_data); end
      if (acc_ready !== 1'b1) begin bad++; $display("FAIL reset_acc_ready: got %b exp 1", acc_ready); end
      if (ovf_flag !== 1'b0) begin bad++; $display("FAIL reset_ovf_flag: got %b exp 0", ovf_flag); end
      if (sat_cnt !== 16'h0) begin bad++; $display("FAIL reset_sat_cnt: got %h exp 0000", sat_cnt); end
   endtask

   task automatic test_latency;
      pulse(40'h00_0000_1234, 32'h0, 6'd0);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_k: out_valid got %b exp 0", out_valid); end
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_k1: out_valid got %b exp 0", out_valid); end
      tick();
      total += 2;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_k2: out_valid got %b exp 1", out_valid); end
      if (out_data !== 16'h1234) begin bad++; $display("FAIL lat_data: got %h exp 1234", out_data); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_pop: out_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_rounding;
      longint      acc_t [4] = '{24, 23, -24, 8};
      longint      bias_t[4] = '{0, 0, 0, 8};
      logic [15:0] exp_t [4] = '{16'h0002, 16'h0001, 16'hFFFF, 16'h0001};
      logic        v;
      logic [15:0] d;
      for (int i = 0; i < 4; i++) begin
         one_result(40'(acc_t[i]), 32'(bias_t[i]), 6'd4, v, d);
         total += 2;
         if (v !== 1'b1) begin bad++; $display("FAIL round_valid[%0d]: got %b exp 1", i, v); end
         if (d !== exp_t[i]) begin bad++; $display("FAIL round_data[%0d]: got %h exp %h", i, d, exp_t[i]); end
      end
   endtask

   task automatic test_saturation;
      logic        v;
      logic [15:0] d;
      logic [15:0] exp_neg;
      logic [15:0] exp_cnt;
`ifdef REQUANT_RELU_EN
      exp_neg = 16'h0000;
      exp_cnt = 16'd1;
`else
      exp_neg = 16'h8000;
      exp_cnt = 16'd2;
`endif
      clear_flags();
      one_result(40'd65536, 32'h0, 6'd0, v, d);
      total += 2;
      if (d !== 16'h7FFF) begin bad++; $display("FAIL sat_pos: got %h exp 7fff", d); end
      if (sat_cnt !== 16'd1) begin bad++; $display("FAIL sat_cnt1: got %0d exp 1", sat_cnt); end
      one_result(-40'sd65536, 32'h0, 6'd0, v, d);
      total += 2;
      if (d !== exp_neg) begin bad++; $display("FAIL sat_neg: got %h exp %h", d, exp_neg); end
      if (sat_cnt !== exp_cnt) begin bad++; $display("FAIL sat_cnt2: got %0d exp %0d", sat_cnt, exp_cnt); end
      one_result(40'h80_0000_0000, 32'h8000_0000, 6'd63, v, d);
      total++;
      if (d !== 16'hFFFF) begin bad++; $display("FAIL sat_clamp_shift: got %h exp ffff", d); end
   endtask

   task automatic test_overflow;
      bit saw_low = 1'b0;
      clear_flags();
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         if (!acc_ready)
            saw_low = 1'b1;
         acc_valid = 1'b1;
         acc_in = 40'(i);
         bias = '0;
         shift_amt = '0;
         tick();
      end
      acc_valid = 1'b0;
      tick(); tick(); tick();
      total += 2;
      if (saw_low !== 1'b1) begin bad++; $display("FAIL ovf_acc_ready: low seen %b exp 1", saw_low); end
      if (ovf_flag !== 1'b1) begin bad++; $display("FAIL ovf_flag_set: got %b exp 1", ovf_flag); end
      for (int i = 1; i <= 4; i++) begin
         total += 2;
         if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_drain_valid[%0d]: got %b exp 1", i, out_valid); end
         if (out_data !== 16'(i)) begin bad++; $display("FAIL ovf_drain_data[%0d]: got %h exp %h", i, out_data, 16'(i)); end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: out_valid got %b exp 0", out_valid); end
      clear_flags();
      total++;
      if (ovf_flag !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b exp 0", ovf_flag); end
   endtask

   task automatic test_full_pop;
      logic [15:0] exp_q [4] = '{16'd12, 16'd13, 16'd14, 16'd50};
      clear_flags();
      out_ready = 1'b0;
      for (int i = 11; i <= 14; i++) begin
         acc_valid = 1'b1;
         acc_in = 40'(i);
         bias = '0;
         shift_amt = '0;
         tick();
      end
      acc_valid = 1'b0;
      tick(); tick(); tick();
      total++;
      if (acc_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b exp 0", acc_ready); end
      pulse(40'd50, 32'h0, 6'd0);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total += 2;
      if (ovf_flag !== 1'b0) begin bad++; $display("FAIL full_pop_ovf: got %b exp 0", ovf_flag); end
      if (acc_ready !== 1'b0) begin bad++; $display("FAIL full_pop_count: acc_ready got %b exp 0", acc_ready); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (out_data !== exp_q[i]) begin bad++; $display("FAIL full_pop_data[%0d]: got %h exp %h", i, out_data, exp_q[i]); end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL full_pop_empty: got %b exp 0", out_valid); end
   endtask

   task automatic test_reset_midop;
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         acc_valid = 1'b1;
         acc_in = 40'(i + 20);
         tick();
      end
      acc_valid = 1'b0;
      tick(); tick(); tick();
      pulse(40'd7, 32'h0, 6'd0);
      acc_valid = 1'b1;
      acc_in = 40'd8;
      tick();
      acc_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total += 2;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b exp 0", out_valid); end
      if (out_data !== 16'h0) begin bad++; $display("FAIL rst_mid_data: got %h exp 0000", out_data); end
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale[%0d]: out_valid got %b exp 0", i, out_valid); end
      end
      out_ready = 1'b0;
      total++;
      if (acc_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b exp 1", acc_ready); end
   endtask

   task automatic test_random;
      logic [15:0] q[$];
      int          exp_sat = 0;
      longint      r, a, b;
      int          w, sh;
      bit          s;
      int          ws[4] = '{8, 17, 24, 40};
      clear_flags();
      for (int c = 0; c < 500; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (acc_ready && ($urandom_range(0, 2) != 0)) begin
            r = {$urandom(), $urandom()};
            w = ws[$urandom_range(0, 3)];
            a = (r <<< (64 - w)) >>> (64 - w);
            b = ($urandom_range(0, 1) != 0) ? longint'(int'($urandom_range(0, 2000)) - 1000)
                                             : longint'(int'($urandom()));
            sh = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 63));
            acc_valid = 1'b1;
            acc_in = a[39:0];
            bias = b[31:0];
            shift_amt = 6'(sh);
            q.push_back(model(a, b, sh, s));
            if (s)
               exp_sat++;
         end else begin
            acc_valid = 1'b0;
         end
         #1;
         if (out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL rand_extra: got %h exp none", out_data);
            end else begin
               if (out_data !== q[0]) begin bad++; $display("FAIL rand_data[%0d]: got %h exp %h", c, out_data, q[0]); end
               void'(q.pop_front());
            end
         end
         tick();
      end
      acc_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL rand_drain_extra: got %h exp none", out_data);
            end else begin
               if (out_data !== q[0]) begin bad++; $display("FAIL rand_drain[%0d]: got %h exp %h", c, out_data, q[0]); end
               void'(q.pop_front());
            end
         end
         tick();
      end
      out_ready = 1'b0;
      total += 3;
      if (q.size() != 0) begin bad++; $display("FAIL rand_missing: got %0d left exp 0", q.size()); end
      if (ovf_flag !== 1'b0) begin bad++; $display("FAIL rand_ovf: got %b exp 0", ovf_flag); end
      if (sat_cnt !== 16'(exp_sat)) begin bad++; $display("FAIL rand_sat_cnt: got %0d exp %0d", sat_cnt, exp_sat); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_rounding();
      test_saturation();
      test_overflow();
      test_full_pop();
      test_reset_midop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
